// File: rtl/rotary_quad_gen.sv
// rtl/rotary_quad_gen.sv - rotary-encoder emulator driving a Gray-code quadrature pair
// Optional contact bounce on every phase edge: define ROTGEN_BOUNCE_EN.
module rotary_quad_gen #(
  parameter int STEP_CYCLES    = 1000,
  parameter int PEND_W         = 4,
  parameter int BOUNCE_TOGGLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     step_cw,
  input  logic                     step_ccw,
  output logic [1:0]               rotary_out,
  output logic                     busy,
  output logic signed [PEND_W-1:0] pending,
  output logic                     detent_done,
  output logic                     overflow
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam int EXT_W = PEND_W + 2;
  localparam logic signed [EXT_W-1:0] P_MAX = EXT_W'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] P_MIN = -P_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [1:0]                r_ph, w_ph_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_dir_cw, w_dir_nxt;
  logic [1:0]                r_out, w_out_nxt;
  logic                      r_done, w_done_nxt;
  logic signed [PEND_W-1:0]  r_pend, w_pend_nxt;
  logic                      r_ovf, w_ovf_nxt;
  logic                      w_start;
  logic                      w_cnt_last;
  logic signed [EXT_W-1:0]   w_pend_ext, w_delta, w_consume, w_sum;

  // Anticlockwise is the clockwise sequence with A and B swapped.
  function automatic logic [1:0] phase_code(input logic dir_cw, input logic [1:0] ph);
    logic [1:0] code;
    case (ph)
      2'd0:    code = 2'b11;
      2'd1:    code = 2'b10;
      2'd2:    code = 2'b00;
      default: code = 2'b01;
    endcase
    return dir_cw ? code : {code[0], code[1]};
  endfunction

  assign w_start    = (r_state == S_IDLE) && (r_pend != '0);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Request and consume are summed at full width before saturation.
  always_comb begin
    w_pend_ext = {{2{r_pend[PEND_W-1]}}, r_pend};
    w_delta    = '0;
    if (step_cw && !step_ccw) begin
      w_delta = EXT_W'(1);
    end else if (!step_cw && step_ccw) begin
      w_delta = '1;
    end
    w_consume = '0;
    if (w_start) begin
      w_consume = r_pend[PEND_W-1] ? '1 : EXT_W'(1);
    end
    w_sum      = w_pend_ext + w_delta - w_consume;
    w_pend_nxt = w_sum[PEND_W-1:0];
    w_ovf_nxt  = r_ovf;
    if (w_sum > P_MAX) begin
      w_pend_nxt = P_MAX[PEND_W-1:0];
      w_ovf_nxt  = 1'b1;
    end else if (w_sum < P_MIN) begin
      w_pend_nxt = P_MIN[PEND_W-1:0];
      w_ovf_nxt  = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir_cw;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_dir_nxt   = ~r_pend[PEND_W-1];
          w_ph_nxt    = 2'd1;
          w_cnt_nxt   = '0;
          w_out_nxt   = phase_code(~r_pend[PEND_W-1], 2'd1);
          w_state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (r_ph == 2'd3) begin
            w_ph_nxt    = 2'd0;
            w_out_nxt   = 2'b11;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DWELL;
          end else begin
            w_ph_nxt  = r_ph + 2'd1;
            w_out_nxt = phase_code(r_dir_cw, r_ph + 2'd1);
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DWELL: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_ph_nxt    = 2'd0;
        w_out_nxt   = 2'b11;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ph     <= 2'd0;
      r_cnt    <= '0;
      r_dir_cw <= 1'b1;
      r_out    <= 2'b11;
      r_done   <= 1'b0;
      r_pend   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph     <= w_ph_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_cw <= w_dir_nxt;
      r_out    <= w_out_nxt;
      r_done   <= w_done_nxt;
      r_pend   <= w_pend_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

`ifdef ROTGEN_BOUNCE_EN
  localparam int BOUNCE_W = 2 * BOUNCE_TOGGLES;

  logic [1:0] r_prev;
  logic       w_bounce;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 2'b11;
    end else if (w_out_nxt != r_out) begin
      r_prev <= r_out;
    end
  end

  // Odd cycles inside the bounce window show the pre-edge level again.
  assign w_bounce   = (r_state != S_IDLE) && (int'(r_cnt) < BOUNCE_W) && r_cnt[0];
  assign rotary_out = w_bounce ? r_prev : r_out;
`else
  assign rotary_out = r_out;
`endif

  assign busy        = (r_state != S_IDLE);
  assign pending     = r_pend;
  assign detent_done = r_done;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// tb/tb_rotary_quad_gen.sv - scoreboard bench for rotary_quad_gen (clean edge build)
// A detent-position model predicts each output edge and detent_done; a monitor compares.
module tb_rotary_quad_gen;

  localparam int S    = 4;
  localparam int PW   = 4;
  localparam int PMAX = (1 << (PW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 step_cw = 1'b0;
  logic                 step_ccw = 1'b0;
  logic [1:0]           rotary_out;
  logic                 busy;
  logic signed [PW-1:0] pending;
  logic                 detent_done;
  logic                 overflow;

  rotary_quad_gen #(.STEP_CYCLES(S), .PEND_W(PW), .BOUNCE_TOGGLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .step_cw(step_cw), .step_ccw(step_ccw),
    .rotary_out(rotary_out), .busy(busy), .pending(pending),
    .detent_done(detent_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [1:0] code; } edge_t;

  edge_t      exp_q[$];
  int         done_q[$];
  edge_t      mon_e;
  logic [1:0] cw_ring [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] last_out = 2'b11;
  int         cyc = 0;
  int         m_pend = 0;
  int         m_idle_from = 0;
  int         m_d, m_cons, m_sum, m_idx;
  bit         m_ovf = 1'b0;
  bit         m_start;
  int         checks = 0;
  int         errors = 0;
  int         det_count = 0;
  int         d0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected none at cycle %0d", name, act, cyc);
  endtask

  // Detent-position model: each start walks four positions around the ring, one every S cycles.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_pend      = 0;
      m_ovf       = 1'b0;
      m_idle_from = 0;
    end else begin
      m_start = (cyc - 1 >= m_idle_from) && (m_pend != 0);
      m_d     = int'(step_cw) - int'(step_ccw);
      m_cons  = m_start ? ((m_pend > 0) ? 1 : -1) : 0;
      m_sum   = m_pend + m_d - m_cons;
      if (m_sum > PMAX) begin
        m_sum = PMAX;
        m_ovf = 1'b1;
      end else if (m_sum < -PMAX) begin
        m_sum = -PMAX;
        m_ovf = 1'b1;
      end
      m_pend = m_sum;
      if (m_start) begin
        for (int k = 1; k <= 4; k++) begin
          m_idx = (m_cons > 0) ? (k % 4) : ((4 - k) % 4);
          exp_q.push_back('{cyc + (k - 1) * S, cw_ring[m_idx]});
        end
        done_q.push_back(cyc + 3 * S);
        m_idle_from = cyc + 4 * S;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (rotary_out != last_out) begin
        chk("one_bit_edge", $countones(rotary_out ^ last_out), 1);
        if (exp_q.size() == 0) begin
          fail("unexpected_edge", int'(rotary_out));
        end else begin
          mon_e = exp_q.pop_front();
          chk("edge_code", int'(rotary_out), int'(mon_e.code));
          chk("edge_cycle", cyc, mon_e.cyc);
        end
        last_out = rotary_out;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        fail("missing_edge", mon_e.cyc);
      end
      if (detent_done) begin
        det_count++;
        if (done_q.size() == 0) fail("unexpected_done", cyc);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0] < cyc) fail("missing_done", done_q.pop_front());
      chk("pending", int'(pending), m_pend);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("busy", int'(busy), int'(cyc < m_idle_from));
    end
  end

  task automatic drive(input bit cw, input bit ccw, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_cw  = cw;
      step_ccw = ccw;
    end
    @(negedge clk);
    step_cw  = 1'b0;
    step_ccw = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rotary_out"}, int'(rotary_out), 3);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_detent_done"}, int'(detent_done), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    #1;
    check_reset_state("rst_async");
    exp_q.delete();
    done_q.delete();
    last_out = 2'b11;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (exp_q.size() == 0) && (done_q.size() == 0) && (m_pend == 0) && (cyc >= m_idle_from);
    end
    if (!ok) fail({name, "_drain_timeout"}, exp_q.size());
  endtask

  task automatic wait_dets(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (det_count >= target);
    end
    if (!ok) fail("detent_wait_timeout", det_count);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("rst_init");
    reset_n = 1'b1;

    d0 = det_count;
    drive(1'b1, 1'b0, 1);
    wait_drain("single_cw");
    chk("single_cw_detents", det_count - d0, 1);

    d0 = det_count;
    drive(1'b0, 1'b1, 1);
    wait_drain("single_ccw");
    chk("single_ccw_detents", det_count - d0, 1);

    d0 = det_count;
    drive(1'b1, 1'b1, 5);
    repeat (5) @(negedge clk);
    chk("both_high_detents", det_count - d0, 0);

    d0 = det_count;
    drive(1'b1, 1'b0, 10);
    wait_drain("saturation");
    chk("saturation_detents", det_count - d0, 8);
    chk("saturation_overflow_sticky", int'(overflow), 1);
    do_reset();

    d0 = det_count;
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 1);
    repeat (3) drive(1'b0, 1'b1, 1);
    wait_dets(d0 + 2);
    repeat (S + 4) @(negedge clk);
    chk("reversal_detents", det_count - d0, 2);
    chk("busy_before_reset", int'(busy), 1);
    do_reset();
    repeat (S * 5) @(negedge clk);
    chk("no_done_after_reset", det_count - d0, 2);

    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (i < 450) begin
        step_cw  = ($urandom_range(0, 11) == 0);
        step_ccw = ($urandom_range(0, 11) == 0);
      end else begin
        step_cw  = ($urandom_range(0, 2) == 0);
        step_ccw = ($urandom_range(0, 5) == 0);
      end
    end
    @(negedge clk);
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    wait_drain("random");
    chk("final_edge_queue", exp_q.size(), 0);
    chk("final_done_queue", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
